// File: rtl/pipe_pkg.sv
// pipe_pkg: shared default widths and control-bundle bit positions for pipeline stage registers
package pipe_pkg;
  localparam int CTRL_W_DEF = 3;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int REG_WRITE = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_TO_REG = 2;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+ctrl+data holding register with load enable and valid clear
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  logic              valid_q = 1'b0;
  logic [CTRL_W-1:0] ctrl_q = '0;
  logic [DATA_W-1:0] data_q = '0;
  // clear beats load so a kill never lets a new entry slip in; payload holds unless loaded
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= in_ctrl;
      data_q  <= in_data;
    end
  end
  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush and saturating stall counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_count
);
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_src_data;
  logic              accept, consume;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [CNT_W-1:0]  cnt = '0;
  // transfer decisions; in_ready comes only from skid state so out_ready never reaches it
  always_comb begin
    in_ready      = !skid_valid;
    accept        = in_valid && !skid_valid && !flush;
    consume       = main_valid && out_ready;
    main_load     = (consume && skid_valid) || (accept && (!main_valid || consume));
    main_clear    = flush || (consume && !skid_valid && !accept);
    skid_load     = accept && main_valid && !consume;
    skid_clear    = flush || (consume && skid_valid);
    main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    main_src_data = skid_valid ? skid_data : in_data;
  end
  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk(clk), .reset(reset), .load(main_load), .clear(main_clear),
    .in_ctrl(main_src_ctrl), .in_data(main_src_data),
    .valid(main_valid), .ctrl(main_ctrl), .data(main_data)
  );
  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .clear(skid_clear),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
  );
  // count backpressured cycles, sticking at all-ones; flush leaves it alone
  always_ff @(posedge clk) begin
    if (!reset) cnt <= '0;
    else if (main_valid && !out_ready && cnt != '1) cnt <= cnt + CNT_W'(1);
  end
  assign out_valid   = main_valid;
  assign out_ctrl    = main_valid ? main_ctrl : '0;
  assign out_data    = main_data;
  assign stall_count = cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg against a queue-based behavioural model
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [2:0]  out_ctrl, out_ctrl4;
  logic [31:0] out_data, out_data4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;
  int checks = 0;
  int errors = 0;
  logic [34:0] q[$];
  logic [15:0] m16 = '0;
  logic [3:0]  m4 = '0;
  logic [31:0] hold = '0;
  logic        acc, con;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .flush(flush), .stall_count(stall_count)
  );
  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ctrl(out_ctrl4), .out_data(out_data4), .flush(flush), .stall_count(stall_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: a FIFO of at most two instructions, head shown at the output
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m16 = '0;
      m4 = '0;
      hold = '0;
    end else begin
      acc = in_valid && q.size() < 2 && !flush;
      con = q.size() > 0 && out_ready;
      if (q.size() > 0 && !out_ready) begin
        if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
        if (m4 != 4'hF) m4 = m4 + 4'd1;
      end
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back({in_ctrl, in_data});
      end
      if (q.size() > 0) hold = q[0][31:0];
    end
  end

  // every cycle: both instances against the model
  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("out_ctrl", {29'd0, out_ctrl}, q.size() > 0 ? {29'd0, q[0][34:32]} : 32'd0);
    chk("out_data", out_data, hold);
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("stall_count", {16'd0, stall_count}, {16'd0, m16});
    chk("out_valid4", {31'd0, out_valid4}, {31'd0, q.size() > 0});
    chk("out_data4", out_data4, hold);
    chk("in_ready4", {31'd0, in_ready4}, {31'd0, q.size() < 2});
    chk("stall_count4", {28'd0, stall_count4}, {28'd0, m4});
  end

  task automatic drive(input logic rn, input logic iv, input logic [2:0] c, input logic [31:0] d,
                       input logic ordy, input logic fl);
    reset = rn;
    in_valid = iv;
    in_ctrl = c;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  int got[$];
  int i, n;
  logic adv, ordy_r;

  initial begin
    drive(0, 1, 3'b111, 32'hFFFF, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", {16'd0, stall_count}, 0);
    drive(1, 1, 3'b101, 32'h1234, 1, 0);
    chk("lat1_valid", {31'd0, out_valid}, 1);
    chk("lat1_ctrl", {29'd0, out_ctrl}, 5);
    chk("lat1_data", out_data, 32'h1234);
    drive(1, 0, 0, 0, 1, 0);
    chk("bubble_ctrl", {29'd0, out_ctrl}, 0);
    drive(1, 1, 0, 32'h11, 0, 0);
    chk("a_in_ready", {31'd0, in_ready}, 1);
    drive(1, 1, 0, 32'h22, 0, 0);
    chk("b_in_ready", {31'd0, in_ready}, 0);
    chk("stall_1", {16'd0, stall_count}, 1);
    drive(1, 0, 0, 0, 0, 0);
    chk("stall_2", {16'd0, stall_count}, 2);
    chk("hold_a", out_data, 32'h11);
    drive(1, 0, 0, 0, 1, 0);
    chk("then_b", out_data, 32'h22);
    chk("then_b_valid", {31'd0, out_valid}, 1);
    drive(1, 0, 0, 0, 1, 0);
    chk("drained", {31'd0, out_valid}, 0);
    chk("stall_kept", {16'd0, stall_count}, 2);
    drive(1, 1, 3'b001, 32'hAA, 0, 0);
    drive(1, 1, 3'b010, 32'hBB, 0, 0);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    drive(1, 1, 3'b111, 32'hCC, 1, 1);
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk("flush_ctrl", {29'd0, out_ctrl}, 0);
    chk("flush_in_ready", {31'd0, in_ready}, 1);
    drive(1, 0, 0, 0, 1, 0);
    chk("flush_dropped", {31'd0, out_valid}, 0);
    chk("flush_stall", {16'd0, stall_count}, 3);
    drive(1, 1, 3'b011, 32'h55, 0, 0);
    for (int k = 0; k < 20; k++) drive(1, 0, 0, 0, 0, 0);
    chk("sat4", {28'd0, stall_count4}, 15);
    chk("cnt16", {16'd0, stall_count}, 23);
    drive(1, 0, 0, 0, 1, 0);
    i = 0;
    n = 0;
    while (got.size() < 8 && n < 200) begin
      ordy_r = 1'($urandom_range(0, 1));
      if (out_valid && ordy_r) got.push_back(int'(out_data));
      adv = in_ready && i < 8;
      drive(1, i < 8, i[2:0], i, ordy_r, 0);
      if (adv) i++;
      n++;
    end
    chk("stream_count", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("stream_order", got[k], k);
    drive(1, 1, 3'b110, 32'h77, 0, 0);
    drive(1, 1, 3'b110, 32'h78, 0, 0);
    drive(0, 1, 3'b110, 32'h79, 1, 0);
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_ctrl", {29'd0, out_ctrl}, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    chk("midrst_stall", {16'd0, stall_count}, 0);
    drive(1, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 3, width of control bundle (e.g. reg write, mem write, mem-to-reg select).
REQ-002 SHALL have parameter DATA_W, default 32, width of data payload.
REQ-003 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-006 SHALL have port in_valid  input  1  upstream stage holds a valid instruction.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  output  1  stage presents a valid instruction.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_ctrl  output  CTRL_W  control bundle to downstream.
REQ-013 SHALL have port out_data  output  DATA_W  payload to downstream.
REQ-014 SHALL have port flush  input  1  kill all held and incoming instructions.
REQ-015 SHALL have port stall_count  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL hold two entries: main (drives outputs) and skid; each has a valid bit, ctrl and data.
REQ-017 SHALL drive in_ready = NOT skid_valid, taken from registered state only (no combinational path from out_ready).
REQ-018 SHALL define accept = in_valid AND in_ready AND NOT flush; consume = out_valid AND out_ready.
REQ-019 SHALL drive out_valid = main_valid and out_data = main data, with out_ctrl forced to all-zero whenever main_valid=0 (bubble never asserts a write enable).
REQ-020 SHALL, when main empty or consume, and skid empty, load accepted input into main (latency 1 cycle in to out).
REQ-021 SHALL, when main full, no consume, and accept, load input into skid.
REQ-022 SHALL, on consume with skid valid, move skid into main and clear skid_valid; a simultaneous accept is impossible (in_ready=0).
REQ-023 SHALL, on consume with skid empty and no accept, clear main_valid.
REQ-024 SHALL preserve order: no entry overtakes another; no entry duplicated or dropped except by flush.
REQ-025 SHALL, on flush, clear main_valid and skid_valid next cycle; flush wins over simultaneous accept and consume (the consume still completes downstream that cycle).
REQ-026 SHALL keep main and skid data/ctrl unchanged while not loaded (hold under stall).
REQ-027 SHALL increment stall_count each cycle out_valid=1 and out_ready=0, saturating at all-ones; not cleared by flush.
REQ-028 SHALL sustain one transfer per cycle when out_ready is held 1.

Reset
REQ-029 SHALL, with reset=0 at a rising edge, clear main_valid, skid_valid, all ctrl/data registers and stall_count to 0; reset overrides flush and accept.
REQ-030 SHALL present out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_count=0 in the cycle after reset; reset mid-stall discards both entries.
REQ-031 SHALL initialise all registers to 0 at time zero for simulation.

Structure
REQ-032 SHALL place default widths and the control bundle bit indices (REG_WRITE=0, MEM_WRITE=1, MEM_TO_REG=2) in shared package pipe_pkg.
REQ-033 SHALL contain one sub-module, pipe_entry (valid+ctrl+data register with load enable and clear), instantiated twice.
REQ-034 SHALL contain no latches and no combinational in-to-out path.

Verification
REQ-035 SHALL cover: reset=0 then 1, in_valid=1 ctrl=3'b101 data=0x1234, out_ready=1 -> next cycle out_valid=1, out_ctrl=3'b101, out_data=0x1234.
REQ-036 SHALL cover: out_ready=0, send A=0x11, B=0x22 -> in_ready=0 after B, stall_count increments per cycle; out_ready=1 -> A then B on consecutive cycles.
REQ-037 SHALL cover: main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, input dropped.
REQ-038 SHALL cover: CNT_W=4, out_ready=0 for 20 cycles with valid entry -> stall_count saturates at 15.
REQ-039 SHALL cover: streaming 8 words 0x0..0x7 with random out_ready -> identical ordered output, no loss/duplication; reset=0 mid-stream -> all outputs 0 next cycle.
